// File: rtl/noc_output_lock.sv
// Output-port packet lock: holds the arbiter winner from head to tail flit.
// Optional NOC_OUTPUT_PIPE_EN adds a 1-entry output register before the link.
module noc_output_lock #(
    parameter int N_INPUTS   = 2,
    parameter int FLIT_WIDTH = 34,
    parameter int IDX_W      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic [N_INPUTS-1:0]            in_valid_i,
    input  logic [N_INPUTS*FLIT_WIDTH-1:0] in_flit_i,
    output logic [N_INPUTS-1:0]            in_ready_o,
    output logic [N_INPUTS-1:0]            arb_req_o,
    input  logic [N_INPUTS-1:0]            arb_grant_i,
    output logic                           arb_update_o,
    output logic                           out_valid_o,
    output logic [FLIT_WIDTH-1:0]          out_flit_o,
    input  logic                           out_ready_i,
    output logic                           lock_o,
    output logic [IDX_W-1:0]               owner_o
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;

    logic [N_INPUTS-1:0]   head_req;
    logic [IDX_W-1:0]      grant_idx;
    logic                  lock_ok;
    logic                  locked;
    logic                  sel_valid;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic                  sel_tail;
    logic                  accept;
    logic                  done;

    assign locked    = (state_q == LOCKED);
    assign sel_valid = in_valid_i[owner_q];
    assign sel_flit  = in_flit_i[int'(owner_q)*FLIT_WIDTH +: FLIT_WIDTH];
    // TAIL (10) and HEAD_TAIL (11) both carry the upper type bit
    assign sel_tail  = sel_flit[FLIT_WIDTH-1];

    always_comb begin
        head_req  = '0;
        grant_idx = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            logic [1:0] typ;
            typ = in_flit_i[k*FLIT_WIDTH+FLIT_WIDTH-2 +: 2];
            head_req[k] = in_valid_i[k] && (typ[1] == typ[0]);
            if (arb_grant_i[k]) grant_idx = IDX_W'(k);
        end
    end

    assign lock_ok = !arst && !locked && $onehot(arb_grant_i)
                     && |(arb_grant_i & head_req);

`ifdef NOC_OUTPUT_PIPE_EN
    logic                  full_q, full_d;
    logic [FLIT_WIDTH-1:0] data_q, data_d;

    assign accept = locked && sel_valid && (!full_q || out_ready_i);

    always_comb begin
        full_d = accept || (full_q && !out_ready_i);
        data_d = accept ? sel_flit : data_q;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        in_ready_o = '0;
        for (int k = 0; k < N_INPUTS; k++)
            in_ready_o[k] = !arst && locked && (owner_q == IDX_W'(k))
                            && (!full_q || out_ready_i);
    end

    assign out_valid_o = !arst && full_q;
    assign out_flit_o  = arst ? '0 : data_q;
`else
    assign accept = locked && sel_valid && out_ready_i;

    always_comb begin
        in_ready_o = '0;
        for (int k = 0; k < N_INPUTS; k++)
            in_ready_o[k] = !arst && locked && (owner_q == IDX_W'(k))
                            && out_ready_i;
    end

    assign out_valid_o = !arst && locked && sel_valid;
    assign out_flit_o  = (!arst && locked) ? sel_flit : '0;
`endif

    assign done = accept && sel_tail;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (lock_ok) begin
                    state_d = LOCKED;
                    owner_d = grant_idx;
                end
            end
            LOCKED: begin
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign arb_req_o    = (!arst && !locked) ? head_req : '0;
    assign arb_update_o = lock_ok;
    assign lock_o       = !arst && locked;
    assign owner_o      = arst ? '0 : owner_q;

endmodule

// File: tb/tb_noc_output_lock.sv
// Directed bench for noc_output_lock in the default pass-through build.
// Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
module tb_noc_output_lock;

    localparam int N  = 2;
    localparam int FW = 34;

    localparam logic [1:0] HEAD = 2'b00;
    localparam logic [1:0] BODY = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;
    localparam logic [1:0] HT   = 2'b11;

    logic            clk = 1'b0;
    logic            arst;
    logic [N-1:0]    in_valid_i;
    logic [N*FW-1:0] in_flit_i;
    logic [N-1:0]    in_ready_o;
    logic [N-1:0]    arb_req_o;
    logic [N-1:0]    arb_grant_i;
    logic            arb_update_o;
    logic            out_valid_o;
    logic [FW-1:0]   out_flit_o;
    logic            out_ready_i;
    logic            lock_o;
    logic [0:0]      owner_o;

    logic [FW-1:0] f0, f1;
    int checks = 0;
    int errors = 0;

    noc_output_lock #(.N_INPUTS(N), .FLIT_WIDTH(FW), .IDX_W(1)) dut (
        .clk(clk), .arst(arst),
        .in_valid_i(in_valid_i), .in_flit_i(in_flit_i),
        .in_ready_o(in_ready_o), .arb_req_o(arb_req_o),
        .arb_grant_i(arb_grant_i), .arb_update_o(arb_update_o),
        .out_valid_o(out_valid_o), .out_flit_o(out_flit_o),
        .out_ready_i(out_ready_i), .lock_o(lock_o), .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    assign in_flit_i = {f1, f0};

    function automatic logic [FW-1:0] mk(logic [1:0] t, logic [31:0] p);
        return {t, p};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst = 1'b1;
        in_valid_i = 2'b11;
        f0 = mk(HEAD, 32'h0000_00A0);
        f1 = mk(HEAD, 32'h0000_00B0);
        arb_grant_i = 2'b11;
        out_ready_i = 1'b1;

        // reset with both inputs requesting
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_req", arb_req_o, 0);
            chk("rst_rdy", in_ready_o, 0);
            chk("rst_upd", arb_update_o, 0);
            chk("rst_oval", out_valid_o, 0);
            chk("rst_flit", out_flit_o, 0);
            chk("rst_lock", lock_o, 0);
            chk("rst_own", owner_o, 0);
        end

        // single-flit packet on in0
        arst = 1'b0;
        in_valid_i = 2'b01;
        f0 = mk(HT, 32'h1111_0001);
        arb_grant_i = 2'b01;
        #1;
        chk("sf_req", arb_req_o, 2'b01);
        chk("sf_upd", arb_update_o, 1);
        chk("sf_lock0", lock_o, 0);
        chk("sf_oval0", out_valid_o, 0);
        tick();
        arb_grant_i = 2'b00;
        #1;
        chk("sf_lock1", lock_o, 1);
        chk("sf_own", owner_o, 0);
        chk("sf_oval", out_valid_o, 1);
        chk("sf_flit", out_flit_o, mk(HT, 32'h1111_0001));
        chk("sf_rdy", in_ready_o, 2'b01);
        chk("sf_upd1", arb_update_o, 0);
        chk("sf_lreq", arb_req_o, 0);
        tick();
        in_valid_i = 2'b00;
        #1;
        chk("sf_unlock", lock_o, 0);
        chk("sf_oval2", out_valid_o, 0);

        // 4-flit packet on in1 with in0 head waiting
        in_valid_i = 2'b11;
        f0 = mk(HEAD, 32'h2222_0000);
        f1 = mk(HEAD, 32'h3333_0000);
        arb_grant_i = 2'b10;
        #1;
        chk("p4_req", arb_req_o, 2'b11);
        chk("p4_upd", arb_update_o, 1);
        tick();
        arb_grant_i = 2'b00;
        #1;
        chk("p4_own", owner_o, 1);
        chk("p4_head", out_flit_o, mk(HEAD, 32'h3333_0000));
        chk("p4_rdy", in_ready_o, 2'b10);
        tick();
        f1 = mk(BODY, 32'h3333_0001);
        #1;
        chk("p4_b1", out_flit_o, mk(BODY, 32'h3333_0001));
        tick();
        f1 = mk(BODY, 32'h3333_0002);
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("p4_stall_rdy", in_ready_o, 2'b00);
            chk("p4_stall_val", out_valid_o, 1);
            chk("p4_stall_flit", out_flit_o, mk(BODY, 32'h3333_0002));
            chk("p4_stall_lock", lock_o, 1);
            if (i < 2) tick();
        end
        out_ready_i = 1'b1;
        #1;
        chk("p4_b2_rdy", in_ready_o, 2'b10);
        chk("p4_b2", out_flit_o, mk(BODY, 32'h3333_0002));
        tick();
        f1 = mk(TAIL, 32'h3333_0003);
        #1;
        chk("p4_tail", out_flit_o, mk(TAIL, 32'h3333_0003));
        chk("p4_tail_req", arb_req_o, 2'b00);
        tick();
        in_valid_i = 2'b01;
        #1;
        chk("p4_unlock", lock_o, 0);
        chk("p4_next_req", arb_req_o, 2'b01);
        chk("p4_oval", out_valid_o, 0);

        // contention with alternating grants
        in_valid_i = 2'b11;
        f0 = mk(HT, 32'h4444_0000);
        f1 = mk(HT, 32'h5555_0000);
        for (int i = 0; i < 4; i++) begin
            arb_grant_i = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk("ct_upd", arb_update_o, 1);
            chk("ct_idle", lock_o, 0);
            tick();
            arb_grant_i = 2'b00;
            #1;
            chk("ct_own", owner_o, i % 2);
            chk("ct_flit", out_flit_o,
                (i % 2 == 0) ? mk(HT, 32'h4444_0000) : mk(HT, 32'h5555_0000));
            chk("ct_upd0", arb_update_o, 0);
            tick();
        end

        // bad grants with only in0 requesting
        in_valid_i = 2'b01;
        f0 = mk(HT, 32'h6666_0000);
        arb_grant_i = 2'b11;
        #1;
        chk("bg_req", arb_req_o, 2'b01);
        chk("bg_multi", arb_update_o, 0);
        tick();
        chk("bg_multi_lock", lock_o, 0);
        arb_grant_i = 2'b10;
        #1;
        chk("bg_nonreq", arb_update_o, 0);
        tick();
        chk("bg_nonreq_lock", lock_o, 0);
        arb_grant_i = 2'b00;
        #1;
        chk("bg_zero", arb_update_o, 0);
        tick();
        chk("bg_zero_lock", lock_o, 0);

        // reset mid-packet after two flits
        f0 = mk(HEAD, 32'h7777_0000);
        arb_grant_i = 2'b01;
        #1;
        chk("rm_upd", arb_update_o, 1);
        tick();
        arb_grant_i = 2'b00;
        #1;
        chk("rm_head", out_flit_o, mk(HEAD, 32'h7777_0000));
        tick();
        f0 = mk(BODY, 32'h7777_0001);
        #1;
        chk("rm_b1", out_flit_o, mk(BODY, 32'h7777_0001));
        tick();
        f0 = mk(BODY, 32'h7777_0002);
        arst = 1'b1;
        #1;
        chk("rm_rst_val", out_valid_o, 0);
        chk("rm_rst_rdy", in_ready_o, 0);
        chk("rm_rst_flit", out_flit_o, 0);
        tick();
        arst = 1'b0;
        #1;
        chk("rm_idle", lock_o, 0);
        chk("rm_oval", out_valid_o, 0);
        chk("rm_own", owner_o, 0);
        f0 = mk(HEAD, 32'h7777_0010);
        arb_grant_i = 2'b01;
        #1;
        chk("rm_rereq", arb_req_o, 2'b01);
        chk("rm_reupd", arb_update_o, 1);
        tick();
        arb_grant_i = 2'b00;
        #1;
        chk("rm_relock", lock_o, 1);
        chk("rm_reflit", out_flit_o, mk(HEAD, 32'h7777_0010));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
